// File: rtl/s15850_sel_sweeper_if.sv
// Control/response bundle between the test-control sequencer, the select sweeper
// and the s15850 cone. The optional MISR signature appears when SEL_SWEEP_MISR_EN is defined.
interface s15850_sel_sweeper_if #(
    parameter int NMAX = 16,
    parameter int SELW = 11
);
    localparam int CW = $clog2(NMAX + 1);

    logic            start;
    logic [SELW-1:0] base;
    logic [CW-1:0]   count;
    logic            busy;
    logic [SELW-1:0] sel;
    logic            resp;
    logic [NMAX-1:0] result;
    logic            done;
    logic            wrap;
`ifdef SEL_SWEEP_MISR_EN
    logic [15:0]     sig;

    modport master (output start, base, count, resp,
                    input  busy, sel, result, done, wrap, sig);
    modport slave  (input  start, base, count, resp,
                    output busy, sel, result, done, wrap, sig);
`else
    modport master (output start, base, count, resp,
                    input  busy, sel, result, done, wrap);
    modport slave  (input  start, base, count, resp,
                    output busy, sel, result, done, wrap);
`endif
endinterface

// File: rtl/s15850_sel_sweeper.sv
// Sweeps a range of select codes into the s15850 cone and gathers one response bit per code.
// Define SEL_SWEEP_MISR_EN to add a 16-bit MISR signature of the collected responses.
module s15850_sel_sweeper #(
    parameter int NMAX   = 16,
    parameter int SETTLE = 2,
    parameter int SELW   = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    s15850_sel_sweeper_if.slave   bus
);
    localparam int CW = $clog2(NMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [SELW-1:0] r_code;
    logic [SELW-1:0] r_sel;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_idx;
    logic [3:0]      r_settle;
    logic [NMAX-1:0] r_result;
    logic            r_wrap;

    logic            w_accept;
    logic            w_sample;
    logic            w_last;
    logic [CW-1:0]   w_count;
    logic [NMAX-1:0] w_result_next;
    logic            w_busy;
    logic            w_done;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_sample = (r_state == S_SAMPLE);
    assign w_last   = (r_idx == r_cnt - CW'(1));

    // A zero count still takes one sample; oversize counts saturate at the result width.
    always_comb begin
        w_count = bus.count;
        if (bus.count == '0)
            w_count = CW'(1);
        else if (bus.count > CW'(NMAX))
            w_count = CW'(NMAX);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_DRIVE;
            S_DRIVE:  w_state_next = S_SETTLE;
            S_SETTLE: if (r_settle == 4'd0) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = w_last ? S_DONE : S_DRIVE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_DRIVE, S_SETTLE, S_SAMPLE: w_busy = 1'b1;
            S_DONE:                      w_done = 1'b1;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NMAX; gi++) begin : g_result_bit
            assign w_result_next[gi] = (w_sample && (r_idx == CW'(gi))) ? bus.resp
                                                                        : r_result[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code   <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_settle <= '0;
            r_result <= '0;
            r_wrap   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_code   <= bus.base;
                        r_cnt    <= w_count;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_wrap   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_sel    <= r_code;
                    r_settle <= 4'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (r_settle != 4'd0)
                        r_settle <= r_settle - 4'd1;
                end
                S_SAMPLE: begin
                    r_result <= w_result_next;
                    r_idx    <= r_idx + CW'(1);
                    // The code only advances when another vector follows, so sel holds the last code.
                    if (!w_last) begin
                        r_code <= r_code + SELW'(1);
                        if (&r_code)
                            r_wrap <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEL_SWEEP_MISR_EN
    localparam logic [15:0] MISR_POLY = 16'h100B;

    logic [15:0] r_sig;
    logic [15:0] w_sig_next;

    assign w_sig_next = {r_sig[14:0], 1'b0}
                      ^ ({16{r_sig[15]}} & MISR_POLY)
                      ^ {15'd0, bus.resp};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sig <= '0;
        else if (w_accept)
            r_sig <= 16'hFFFF;
        else if (w_sample)
            r_sig <= w_sig_next;
    end

    assign bus.sig = r_sig;
`endif

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.sel    = r_sel;
    assign bus.result = r_result;
    assign bus.wrap   = r_wrap;

endmodule

// File: tb/tb_s15850_sel_sweeper.sv
// Directed and randomized sweeps of s15850_sel_sweeper against a table-driven cone model.
module tb_s15850_sel_sweeper;
    localparam int NMAX   = 16;
    localparam int SETTLE = 2;
    localparam int SELW   = 11;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bit   tbl [0:2047];
    logic [SELW-1:0] seen [$];
    logic [SELW-1:0] last_sel;
    int   age;

    s15850_sel_sweeper_if #(.NMAX(NMAX), .SELW(SELW)) bus ();

    s15850_sel_sweeper #(.NMAX(NMAX), .SETTLE(SETTLE), .SELW(SELW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cone stand-in: the response only becomes correct once sel has been stable SETTLE cycles.
    always @(negedge clk) begin
        if (bus.sel !== last_sel) begin
            age      = 0;
            last_sel = bus.sel;
            if (bus.busy === 1'b1) seen.push_back(bus.sel);
        end else if (age < 1000) begin
            age++;
        end
        bus.resp = (age >= SETTLE) ? tbl[bus.sel] : ~tbl[bus.sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input bit b);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h1100B;
        return t[15:0] ^ {15'd0, b};
    endfunction

    task automatic run_sweep(input logic [SELW-1:0] base_in, input int cnt_v, input bit poke);
        int n;
        int lat;
        bit got_done;
        bit seq_ok;
        logic [SELW-1:0] base_v;
        logic [SELW-1:0] exp_code [NMAX];
        logic [15:0] exp_res;
        logic [15:0] exp_sig;
        bit exp_wrap;

        base_v = base_in;
        if (base_v == bus.sel) base_v = base_v + 11'd1;
        n = (cnt_v == 0) ? 1 : ((cnt_v > NMAX) ? NMAX : cnt_v);
        exp_res  = '0;
        exp_wrap = 1'b0;
        exp_sig  = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            exp_code[k] = 11'((int'(base_v) + k) % 2048);
            if (k > 0 && exp_code[k] == 11'd0) exp_wrap = 1'b1;
            exp_res[k] = tbl[exp_code[k]];
            exp_sig    = misr_step(exp_sig, tbl[exp_code[k]]);
        end
        seen.delete();

        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = base_v;
        bus.count = 5'(cnt_v);
        lat = 0;
        got_done = 1'b0;
        while (!got_done && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                bus.start = 1'b0;
                check("busy_on_accept", {31'd0, bus.busy}, 32'd1);
            end
            if (poke && lat == 5) begin
                bus.start = 1'b1;
                bus.base  = 11'($urandom);
                bus.count = 5'($urandom_range(1, 3));
            end
            if (poke && lat == 6) bus.start = 1'b0;
            got_done = (bus.done === 1'b1);
        end
        check("done_seen", {31'd0, got_done}, 32'd1);
        check("latency", lat, n * (SETTLE + 2) + 1);
        check("result", {16'd0, bus.result}, {16'd0, exp_res});
        check("wrap", {31'd0, bus.wrap}, {31'd0, exp_wrap});
        check("sel_last", {21'd0, bus.sel}, {21'd0, exp_code[n-1]});
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        seq_ok = (seen.size() == n);
        for (int k = 0; k < n && k < seen.size(); k++)
            if (seen[k] !== exp_code[k]) seq_ok = 1'b0;
        check("sel_sequence", {31'd0, seq_ok}, 32'd1);
`ifdef SEL_SWEEP_MISR_EN
        check("sig", {16'd0, bus.sig}, {16'd0, exp_sig});
`endif
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("result_hold", {16'd0, bus.result}, {16'd0, exp_res});
        $display("[TB] sweep base=%03h count=%0d n=%0d lat=%0d result=%04h wrap=%0b",
                 base_v, cnt_v, n, lat, bus.result, bus.wrap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   {31'd0, bus.busy},   32'd0);
        check({tag, "_done"},   {31'd0, bus.done},   32'd0);
        check({tag, "_sel"},    {21'd0, bus.sel},    32'd0);
        check({tag, "_result"}, {16'd0, bus.result}, 32'd0);
        check({tag, "_wrap"},   {31'd0, bus.wrap},   32'd0);
`ifdef SEL_SWEEP_MISR_EN
        check({tag, "_sig"},    {16'd0, bus.sig},    32'd0);
`endif
    endtask

    initial begin
        bit done_during_abort;
        tests = 0;
        fails = 0;
        age = 0;
        last_sel = '0;
        for (int i = 0; i < 2048; i++) tbl[i] = 1'($urandom);
        bus.start = 1'b0;
        bus.base  = '0;
        bus.count = '0;
        bus.resp  = 1'b0;

        // Reset held for three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_released");

        // Basic sweep with responses 1,0,1,1
        tbl[11'h100] = 1'b1;
        tbl[11'h101] = 1'b0;
        tbl[11'h102] = 1'b1;
        tbl[11'h103] = 1'b1;
        run_sweep(11'h100, 4, 1'b0);
        check("basic_result_const", {16'd0, bus.result}, 32'h0000_000D);

        // Wrap past all-ones
        run_sweep(11'h7FE, 3, 1'b0);
        check("wrap_const", {31'd0, bus.wrap}, 32'd1);

        // Count clamping
        run_sweep(11'h2A5, 0, 1'b0);
        run_sweep(11'h3F0, 20, 1'b0);

        // Start pulsed while busy must be ignored
        run_sweep(11'h100, 4, 1'b1);

        // Abort during the settle window of the second vector
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = 11'h055;
        bus.count = 5'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        done_during_abort = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_during_abort = 1'b1;
        end
        check("abort_no_done", {31'd0, done_during_abort}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(11'h055, 4, 1'b0);

        // Randomized sweeps
        for (int r = 0; r < 8; r++)
            run_sweep(11'($urandom), int'($urandom_range(0, 31)), bit'(r == 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
